pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 16'h0000, giving the first instruction address after reset.
REQ-002 CLK  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 RESETN  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 PC_OFFSETX  input  2  offset select from branch logic, using the shared constants: PC_OFFSETX_2 means +2 and PC_OFFSETX_DIN means DIN; any other code SHALL mean +0.
REQ-005 PC_BASEX  input  2  base select, using the shared constants: PC_BASEX_PC_A means the current instruction address and PC_BASEX_0 means zero; any other code SHALL mean PC_A.
REQ-006 DIN  input  16  jump target or relative displacement.
REQ-007 PC_LOAD  input  1  instruction-complete strobe from the sequencer.
REQ-008 STALL  input  1  when high, SHALL block PC_LOAD.
REQ-009 FETCH_ACK  input  1  memory has accepted the fetch address.
REQ-010 FETCH_REQ  output  1  fetch request, driven from the registered state.
REQ-011 PC  output  16  next fetch address (registered).
REQ-012 PC_A  output  16  address of the instruction in execution (registered).
REQ-013 RET_ADDR  output  16  SHALL equal PC_A+2 (combinational), for call linkage.
REQ-014 INSTR_VALID  output  1  high while in EXEC.
REQ-015 ALIGN_FAULT  output  1  sticky flag set on an odd branch target.

Function
REQ-016 The block SHALL implement three states: BOOT, FETCH and EXEC.
REQ-017 BOOT SHALL go to FETCH unconditionally on the first clock edge after RESETN deasserts; FETCH_REQ=0 in BOOT.
REQ-018 In FETCH: FETCH_REQ=1 and PC stable until FETCH_ACK=1; on that edge PC_A<=PC and state<=EXEC.
REQ-019 FETCH_ACK in the same cycle FETCH_REQ first rises SHALL be accepted, so FETCH lasts a minimum of 1 cycle.
REQ-020 In EXEC, when PC_LOAD=1 and STALL=0: PC<=(base+offset) mod 2^16 with bit 0 forced to 0, and state<=FETCH; base and offset are sampled that cycle.
REQ-021 Additions SHALL be 16-bit unsigned, wrapping: 16'hFFFE+2 = 16'h0000; DIN is used as a two's-complement displacement.
REQ-022 If the computed target has bit 0 = 1, ALIGN_FAULT SHALL set to 1 and remain set until reset; the PC still loads with bit 0 cleared.
REQ-023 PC_LOAD with STALL=1 SHALL be ignored: state, PC and PC_A are held.
REQ-024 PC_LOAD outside EXEC SHALL be ignored.
REQ-025 FETCH_ACK outside FETCH SHALL be ignored.
REQ-026 Latency: PC_LOAD accepted in cycle n SHALL give the new PC and FETCH_REQ=1 in cycle n+1.
REQ-027 Unacknowledged FETCH SHALL persist indefinitely; there is no timeout.
REQ-028 PC_A SHALL change only on FETCH_ACK acceptance.
REQ-029 PC SHALL change only on accepted PC_LOAD or reset.

Reset
REQ-030 While RESETN=0: state=BOOT, PC=RESET_VECTOR, PC_A=RESET_VECTOR, FETCH_REQ=0, INSTR_VALID=0, ALIGN_FAULT=0; these take effect immediately, without waiting for a clock edge.
REQ-031 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation; pending PC_LOAD/FETCH_ACK SHALL be discarded and the first request after release SHALL be to RESET_VECTOR.
REQ-032 RESET_VECTOR SHALL have bit 0 = 0; an odd value is a configuration error and is not checked.

Verification
REQ-033 Sequential run: reset, ack every fetch, PC_OFFSETX_2/PC_BASEX_PC_A with PC_LOAD each EXEC -> fetch addresses 0000, 0002, 0004; RET_ADDR=0002 while PC_A=0000.
REQ-034 Absolute jump: PC_A=0010, PC_OFFSETX_DIN/PC_BASEX_0, DIN=1234 -> next FETCH_REQ with PC=1234 one cycle after PC_LOAD.
REQ-035 Relative jump and wrap: PC_A=FFFE with +2 -> PC=0000; PC_A=0100 with DIN=FFFC relative -> PC=00FC.
REQ-036 Stall and ignore: STALL=1 with PC_LOAD for 3 cycles -> PC and state held; release STALL -> load occurs; PC_LOAD during FETCH -> no change.
REQ-037 Fault: absolute DIN=0123 -> PC=0122 and ALIGN_FAULT=1, still 1 after 10 further instructions; only RESETN=0 clears it.
REQ-038 Async reset: assert RESETN=0 mid-FETCH with FETCH_ACK=0 -> FETCH_REQ=0 immediately; after release, BOOT then FETCH at RESET_VECTOR.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with BOOT/FETCH/EXEC sequencing, branch target computation and sticky alignment fault
package pc_unit_pkg;
  localparam logic [1:0] PC_OFFSETX_0   = 2'd0;
  localparam logic [1:0] PC_OFFSETX_2   = 2'd1;
  localparam logic [1:0] PC_OFFSETX_DIN = 2'd2;
  localparam logic [1:0] PC_BASEX_PC_A  = 2'd0;
  localparam logic [1:0] PC_BASEX_0     = 2'd1;
endpackage

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  pc_offsetx,
  input  logic [1:0]  pc_basex,
  input  logic [15:0] din,
  input  logic        pc_load,
  input  logic        stall,
  input  logic        fetch_ack,
  output logic        fetch_req,
  output logic [15:0] pc,
  output logic [15:0] pc_a,
  output logic [15:0] ret_addr,
  output logic        instr_valid,
  output logic        align_fault
);
  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;
  state_t state;
  logic [15:0] base, offset, target;
  logic load;
  // Branch target: unknown base codes fall back to PC_A, unknown offset codes mean +0
  always_comb begin
    base   = pc_basex == PC_BASEX_0 ? 16'h0000 : pc_a;
    offset = pc_offsetx == PC_OFFSETX_2 ? 16'd2 : pc_offsetx == PC_OFFSETX_DIN ? din : 16'h0000;
    target = base + offset;
    load   = state == EXEC && pc_load && !stall;
  end
  assign ret_addr    = pc_a + 16'd2;
  assign fetch_req   = state == FETCH;
  assign instr_valid = state == EXEC;
  // Sequencer state, fetch/exec addresses and the sticky odd-target flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pc_a        <= RESET_VECTOR;
      align_fault <= 1'b0;
    end else begin
      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (fetch_ack) begin
          pc_a  <= pc;
          state <= EXEC;
        end
        EXEC:  if (load) begin
          pc    <= {target[15:1], 1'b0};
          state <= FETCH;
          if (target[0]) align_fault <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven check of pc_unit sequencing, branch arithmetic, stall, fault and async reset
module tb_pc_unit;
  import pc_unit_pkg::*;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pc_offsetx = PC_OFFSETX_0;
  logic [1:0]  pc_basex = PC_BASEX_PC_A;
  logic [15:0] din = 16'h0000;
  logic        pc_load = 1'b0;
  logic        stall = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        fetch_req, instr_valid, align_fault;
  logic [15:0] pc, pc_a, ret_addr;
  int n_chk = 0;
  int n_fail = 0;

  pc_unit dut (
    .clk(clk), .resetn(resetn), .pc_offsetx(pc_offsetx), .pc_basex(pc_basex), .din(din),
    .pc_load(pc_load), .stall(stall), .fetch_ack(fetch_ack), .fetch_req(fetch_req), .pc(pc),
    .pc_a(pc_a), .ret_addr(ret_addr), .instr_valid(instr_valid), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  basex;
    logic [1:0]  offx;
    logic [15:0] din;
    logic [15:0] exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch();
    int n = 0;
    while (!fetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_wait", {15'd0, fetch_req}, 16'd1);
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] b, input logic [1:0] o, input logic [15:0] d);
    pc_basex = b;
    pc_offsetx = o;
    din = d;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  vec_t vecs[12];
  logic [15:0] prev;

  initial begin
    vecs[0]  = '{PC_BASEX_PC_A, PC_OFFSETX_2,   16'h0000, 16'h0002};
    vecs[1]  = '{PC_BASEX_PC_A, PC_OFFSETX_2,   16'h0000, 16'h0004};
    vecs[2]  = '{PC_BASEX_0,    PC_OFFSETX_DIN, 16'h0010, 16'h0010};
    vecs[3]  = '{PC_BASEX_0,    PC_OFFSETX_DIN, 16'h1234, 16'h1234};
    vecs[4]  = '{PC_BASEX_0,    PC_OFFSETX_DIN, 16'hFFFE, 16'hFFFE};
    vecs[5]  = '{PC_BASEX_PC_A, PC_OFFSETX_2,   16'h0000, 16'h0000};
    vecs[6]  = '{PC_BASEX_0,    PC_OFFSETX_DIN, 16'h0100, 16'h0100};
    vecs[7]  = '{PC_BASEX_PC_A, PC_OFFSETX_DIN, 16'hFFFC, 16'h00FC};
    vecs[8]  = '{PC_BASEX_PC_A, 2'd3,           16'h5555, 16'h00FC};
    vecs[9]  = '{2'd3,          PC_OFFSETX_2,   16'h0000, 16'h00FE};
    vecs[10] = '{PC_BASEX_0,    PC_OFFSETX_0,   16'h7777, 16'h0000};
    vecs[11] = '{PC_BASEX_0,    PC_OFFSETX_DIN, 16'h0200, 16'h0200};

    #2;
    chk("rst_fetch_req", {15'd0, fetch_req}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc_a", pc_a, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_fault", {15'd0, align_fault}, 16'd0);
    @(negedge clk);
    fetch_ack = 1'b1;
    resetn = 1'b1;
    chk("boot_req", {15'd0, fetch_req}, 16'd0);
    @(negedge clk);
    fetch_ack = 1'b0;
    chk("boot_pc_a_hold", pc_a, 16'h0000);
    chk("first_req", {15'd0, fetch_req}, 16'd1);

    prev = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_fetch_pc", i), pc, prev);
      do_fetch();
      chk($sformatf("v%0d_pc_a", i), pc_a, prev);
      chk($sformatf("v%0d_ret", i), ret_addr, prev + 16'd2);
      chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, 16'd1);
      do_load(vecs[i].basex, vecs[i].offx, vecs[i].din);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_req", i), {15'd0, fetch_req}, 16'd1);
      chk($sformatf("v%0d_fault", i), {15'd0, align_fault}, 16'd0);
      prev = vecs[i].exp_pc;
    end

    do_fetch();
    chk("stall_pc_a", pc_a, 16'h0200);
    pc_basex = PC_BASEX_0;
    pc_offsetx = PC_OFFSETX_DIN;
    din = 16'h0040;
    pc_load = 1'b1;
    stall = 1'b1;
    fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_pc", i), pc, 16'h0200);
      chk($sformatf("stall%0d_pc_a", i), pc_a, 16'h0200);
      chk($sformatf("stall%0d_valid", i), {15'd0, instr_valid}, 16'd1);
    end
    fetch_ack = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    pc_load = 1'b0;
    chk("unstall_pc", pc, 16'h0040);
    chk("unstall_req", {15'd0, fetch_req}, 16'd1);

    din = 16'h0300;
    pc_load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("fload%0d_pc", i), pc, 16'h0040);
      chk($sformatf("fload%0d_req", i), {15'd0, fetch_req}, 16'd1);
      chk($sformatf("fload%0d_valid", i), {15'd0, instr_valid}, 16'd0);
    end
    pc_load = 1'b0;
    do_fetch();
    chk("fload_pc_a", pc_a, 16'h0040);

    do_load(PC_BASEX_0, PC_OFFSETX_DIN, 16'h0123);
    chk("fault_pc", pc, 16'h0122);
    chk("fault_set", {15'd0, align_fault}, 16'd1);
    prev = 16'h0122;
    for (int i = 0; i < 10; i++) begin
      do_fetch();
      do_load(PC_BASEX_PC_A, PC_OFFSETX_2, 16'h0000);
      prev = prev + 16'd2;
      chk($sformatf("fault%0d_pc", i), pc, prev);
      chk($sformatf("fault%0d_sticky", i), {15'd0, align_fault}, 16'd1);
    end

    chk("pre_rst_req", {15'd0, fetch_req}, 16'd1);
    #2;
    resetn = 1'b0;
    fetch_ack = 1'b1;
    pc_load = 1'b1;
    #1;
    chk("arst_req", {15'd0, fetch_req}, 16'd0);
    chk("arst_pc", pc, 16'h0000);
    chk("arst_pc_a", pc_a, 16'h0000);
    chk("arst_fault", {15'd0, align_fault}, 16'd0);
    @(negedge clk);
    fetch_ack = 1'b0;
    pc_load = 1'b0;
    chk("arst_hold_req", {15'd0, fetch_req}, 16'd0);
    resetn = 1'b1;
    #1;
    chk("rel_boot_req", {15'd0, fetch_req}, 16'd0);
    @(negedge clk);
    chk("rel_fetch_req", {15'd0, fetch_req}, 16'd1);
    chk("rel_fetch_pc", pc, 16'h0000);
    do_fetch();
    chk("rel_pc_a", pc_a, 16'h0000);
    chk("rel_ret", ret_addr, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
